// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared pointer widths and Gray/binary conversions for both FIFO halves
package afifo_pkg;

    localparam int AFIFO_DATA_WIDTH = 32;
    localparam int AFIFO_ADDR_WIDTH = 4;

    typedef logic [AFIFO_ADDR_WIDTH-1:0] afifo_ptr_t;

    function automatic afifo_ptr_t bin2gray(input afifo_ptr_t v);
        return v ^ (v >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic afifo_ptr_t gray2bin(input afifo_ptr_t g);
        afifo_ptr_t b;
        b[AFIFO_ADDR_WIDTH-1] = g[AFIFO_ADDR_WIDTH-1];
        for (int i = AFIFO_ADDR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_rx_stage_vector_sync.sv
// rtl/afifo_rx_stage_vector_sync.sv - multi-flop synchroniser for a Gray-coded vector
module Vector_SYNC #(
    parameter int DATA_WIDTH = 4,
    parameter int SYNC_STAGE = 2
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [DATA_WIDTH-1:0] D_IN,
    output logic [DATA_WIDTH-1:0] D_OUT
);

    logic [DATA_WIDTH-1:0] r_stage [SYNC_STAGE];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < SYNC_STAGE; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= D_IN;
            for (int i = 1; i < SYNC_STAGE; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign D_OUT = r_stage[SYNC_STAGE-1];

endmodule

// File: rtl/afifo_rx_stage.sv
// rtl/afifo_rx_stage.sv - read-domain half of the async FIFO: pointer sync, empty/level, registered pop
module afifo_rx_stage
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = AFIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = AFIFO_ADDR_WIDTH,
    parameter int SYNC_STAGE = 2
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [ADDR_WIDTH-1:0] W_PTR_GRAY,
    input  logic [DATA_WIDTH-1:0] R_DATA_Tx,
    output logic [ADDR_WIDTH-1:0] R_PTR_GRAY,
    output logic [ADDR_WIDTH-1:0] R_PTR_Binary,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  R_VALID,
    input  logic                  R_READY,
    output logic                  R_EMPTY,
    output logic [ADDR_WIDTH-1:0] R_LEVEL
);

    logic [ADDR_WIDTH-1:0] w_sync_w;
    logic [ADDR_WIDTH-1:0] w_sync_w_bin;
    logic [ADDR_WIDTH-1:0] w_ptr_bin_inc;
    logic                  w_empty;
    logic                  w_pop;

    logic [ADDR_WIDTH-1:0] r_ptr_bin;
    logic [ADDR_WIDTH-1:0] r_ptr_gray;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    Vector_SYNC #(
        .DATA_WIDTH (ADDR_WIDTH),
        .SYNC_STAGE (SYNC_STAGE)
    ) u_w_ptr_sync (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .D_IN  (W_PTR_GRAY),
        .D_OUT (w_sync_w)
    );

    assign w_sync_w_bin  = gray2bin(w_sync_w);
    assign w_ptr_bin_inc = r_ptr_bin + ADDR_WIDTH'(1);

    // Empty is judged on the late-seen write pointer, so it can only err towards empty.
    assign w_empty = (r_ptr_gray == w_sync_w);
    assign w_pop   = ~w_empty & (~r_valid | R_READY);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ptr_bin  <= '0;
            r_ptr_gray <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else if (w_pop) begin
            r_ptr_bin  <= w_ptr_bin_inc;
            r_ptr_gray <= bin2gray(w_ptr_bin_inc);
            r_data     <= R_DATA_Tx;
            r_valid    <= 1'b1;
        end else if (R_READY) begin
            r_valid    <= 1'b0;
        end
    end

    assign R_PTR_GRAY   = r_ptr_gray;
    assign R_PTR_Binary = r_ptr_bin;
    assign R_DATA       = r_data;
    assign R_VALID      = r_valid;
    assign R_EMPTY      = w_empty;
    assign R_LEVEL      = w_sync_w_bin - r_ptr_bin;

endmodule

// File: tb/tb_afifo_rx_stage.sv
// tb/tb_afifo_rx_stage.sv - bench for afifo_rx_stage with a behavioural write side and scoreboard
`timescale 1ns/1ps
module tb_afifo_rx_stage;

    logic        CLK = 1'b0;
    logic        wclk = 1'b0;
    logic        RSTn;
    logic [3:0]  W_PTR_GRAY;
    logic [31:0] R_DATA_Tx;
    logic [3:0]  R_PTR_GRAY;
    logic [3:0]  R_PTR_Binary;
    logic [31:0] R_DATA;
    logic        R_VALID;
    logic        R_READY;
    logic        R_EMPTY;
    logic [3:0]  R_LEVEL;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] mem [8];
    logic [3:0]  wptr;
    logic [3:0]  rs1, rs2;
    logic [31:0] exp_q [$];
    logic [31:0] first_word;

    bit          held_v;
    logic [31:0] held_d;
    bit          trk_ok;
    logic [3:0]  prev_bin, prev_gray;
    int          wraps;
    bit          wr_done;

    always #5    CLK  = ~CLK;
    always #6.85 wclk = ~wclk;

    assign R_DATA_Tx = mem[R_PTR_Binary[2:0]];

    afifo_rx_stage dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .W_PTR_GRAY   (W_PTR_GRAY),
        .R_DATA_Tx    (R_DATA_Tx),
        .R_PTR_GRAY   (R_PTR_GRAY),
        .R_PTR_Binary (R_PTR_Binary),
        .R_DATA       (R_DATA),
        .R_VALID      (R_VALID),
        .R_READY      (R_READY),
        .R_EMPTY      (R_EMPTY),
        .R_LEVEL      (R_LEVEL)
    );

    // Write side's view of the read pointer, two flops deep.
    always @(posedge wclk or negedge RSTn) begin
        if (!RSTn) begin
            rs1 <= '0;
            rs2 <= '0;
        end else begin
            rs1 <= R_PTR_GRAY;
            rs2 <= rs1;
        end
    end

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] from_gray(input logic [3:0] g);
        logic [3:0] b;
        int acc;
        acc = 0;
        for (int i = 3; i >= 0; i--) begin
            acc = acc ^ int'(g[i]);
            b[i] = acc[0];
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic wr_push(input logic [31:0] w);
        int guard;
        guard = 0;
        @(posedge wclk);
        while (4'(wptr - from_gray(rs2)) == 4'd8) begin
            @(posedge wclk);
            guard++;
            if (guard > 3000) begin
                chk("wr_full_timeout", 1, 0);
                return;
            end
        end
        mem[wptr[2:0]] = w;
        exp_q.push_back(w);
        wptr = wptr + 4'd1;
        W_PTR_GRAY = to_gray(wptr);
    endtask

    task automatic set_ready(input logic v);
        @(posedge CLK);
        #1 R_READY = v;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge CLK);
        @(negedge CLK);
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_valid_low"}, R_VALID, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RSTn = 1'b0;
        R_READY = 1'b0;
        wptr = '0;
        W_PTR_GRAY = '0;
        exp_q.delete();
        held_v = 0;
        trk_ok = 0;
        repeat (2) @(negedge CLK);
        #2 RSTn = 1'b1;
    endtask

    // Consumption scoreboard, hold-stability, pointer invariants and wrap tracking.
    initial begin
        forever begin
            @(negedge CLK);
            if (RSTn) begin
                if (held_v) begin
                    chk("hold_valid", R_VALID, 1);
                    chk("hold_data", R_DATA, held_d);
                end
                held_v = R_VALID && !R_READY;
                held_d = R_DATA;
                if (R_VALID && R_READY) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 1, 0);
                    end else begin
                        chk("data_order", R_DATA, exp_q.pop_front());
                    end
                end
                chk("gray_match", R_PTR_GRAY, to_gray(R_PTR_Binary));
                chk("level_bound", R_LEVEL <= 4'd8, 1);
                if (trk_ok && prev_bin == 4'd15 && R_PTR_Binary == 4'd0) begin
                    wraps++;
                    chk("wrap_gray_before", prev_gray, 4'b1000);
                    chk("wrap_gray_after", R_PTR_GRAY, 4'b0000);
                end
                prev_bin  = R_PTR_Binary;
                prev_gray = R_PTR_GRAY;
                trk_ok    = 1;
            end
        end
    end

    initial begin
        logic [31:0] w2 [8];
        for (int i = 0; i < 8; i++) mem[i] = '0;
        RSTn = 1'b0;
        R_READY = 1'b0;
        wptr = '0;
        W_PTR_GRAY = '0;
        held_v = 0;
        trk_ok = 0;
        wraps = 0;
        #22 RSTn = 1'b1;

        @(negedge CLK);
        chk("rst_valid", R_VALID, 0);
        chk("rst_data", R_DATA, 0);
        chk("rst_ptr_bin", R_PTR_Binary, 0);
        chk("rst_ptr_gray", R_PTR_GRAY, 0);
        chk("rst_empty", R_EMPTY, 1);
        chk("rst_level", R_LEVEL, 0);

        // 1: single write, latency measured in read edges
        @(negedge CLK);
        mem[0] = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        wptr = 4'd1;
        W_PTR_GRAY = to_gray(wptr);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("t1_not_yet_valid", R_VALID, 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("t1_valid", R_VALID, 1);
        chk("t1_data", R_DATA, 32'hA5A5_0001);
        chk("t1_ptr_bin", R_PTR_Binary, 1);
        chk("t1_ptr_gray", R_PTR_GRAY, 4'b0001);
        chk("t1_empty", R_EMPTY, 1);
        set_ready(1'b1);
        wait_drain("t1");

        // 2: fill with consumer stalled, then burst out
        set_ready(1'b0);
        for (int i = 0; i < 8; i++) begin
            w2[i] = $urandom;
            wr_push(w2[i]);
        end
        repeat (10) @(negedge CLK);
        chk("t2_valid", R_VALID, 1);
        chk("t2_data_word0", R_DATA, w2[0]);
        chk("t2_level", R_LEVEL, 7);
        chk("t2_empty", R_EMPTY, 0);
        set_ready(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("t2_back_to_back", R_VALID, 1);
        end
        wait_drain("t2");
        chk("t2_empty_after", R_EMPTY, 1);
        chk("t2_level_after", R_LEVEL, 0);

        // 3: 40-word stream from zero pointers, two wraps
        do_reset();
        wraps = 0;
        R_READY = 1'b1;
        for (int i = 0; i < 40; i++) wr_push(32'(i));
        wait_drain("t3");
        chk("t3_wraps", wraps, 2);

        // 4: random data, random consumer back-pressure
        wr_done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    wr_push($urandom);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge wclk);
                end
                wr_done = 1;
            end
            begin
                for (int k = 0; k < 20000 && !wr_done; k++) set_ready(1'($urandom_range(0, 1)));
            end
        join
        set_ready(1'b1);
        wait_drain("t4");

        // 5: empty FIFO with consumer ready
        do_reset();
        set_ready(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("t5_valid", R_VALID, 0);
            chk("t5_ptr_bin", R_PTR_Binary, 0);
            chk("t5_ptr_gray", R_PTR_GRAY, 0);
        end

        // 6: reset while a word is held and five remain
        set_ready(1'b0);
        for (int i = 0; i < 6; i++) wr_push($urandom | 32'h1);
        repeat (10) @(negedge CLK);
        chk("t6_valid_before", R_VALID, 1);
        chk("t6_level_before", R_LEVEL, 5);
        @(negedge CLK);
        #2;
        RSTn = 1'b0;
        wptr = '0;
        W_PTR_GRAY = '0;
        exp_q.delete();
        held_v = 0;
        trk_ok = 0;
        #1;
        chk("t6_valid_rst", R_VALID, 0);
        chk("t6_data_rst", R_DATA, 0);
        chk("t6_ptr_bin_rst", R_PTR_Binary, 0);
        chk("t6_ptr_gray_rst", R_PTR_GRAY, 0);
        @(negedge CLK);
        #2 RSTn = 1'b1;
        repeat (4) @(negedge CLK);
        chk("t6_empty_after", R_EMPTY, 1);
        chk("t6_level_after", R_LEVEL, 0);
        chk("t6_valid_after", R_VALID, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
